// File: rtl/cim_psum_accum.sv
// rtl/cim_psum_accum.sv - bit-serial partial-sum accumulator for quantized CIM column planes
module cim_psum_accum #(
    parameter int NCOL    = 4,
    parameter int Q_W     = 4,
    parameter int IN_BITS = 4,
    parameter int ACC_W   = Q_W + IN_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    q_valid,
    output logic                    q_ready,
    input  logic                    q_first,
    input  logic [NCOL*Q_W-1:0]     q_data,
    input  logic [NCOL-1:0]         q_col_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCOL*ACC_W-1:0]   out_data,
    output logic                    err_restart
);

    localparam int CW = $clog2(IN_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(IN_BITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n, cnt_inc;
    logic [ACC_W-1:0]     acc     [NCOL];
    logic [ACC_W-1:0]     acc_upd [NCOL];
    logic [NCOL*ACC_W-1:0] acc_flat;
    logic                 accept;
    logic                 acc_load;
    logic                 cap;
    logic                 err_n;

    assign q_ready   = !rst && (state != S_HOLD || out_ready);
    assign out_valid = (state == S_HOLD);
    assign accept    = q_valid && q_ready;
    assign cnt_inc   = cnt + ONE;

    // A first-flagged plane restarts the column sum, so the shifted history is dropped.
    always_comb begin
        acc_flat = '0;
        for (int c = 0; c < NCOL; c++) begin
            acc_upd[c] = (q_first ? '0 : {acc[c][ACC_W-2:0], 1'b0})
                       + (q_col_en[c] ? ACC_W'(q_data[c*Q_W +: Q_W]) : '0);
            acc_flat[c*ACC_W +: ACC_W] = acc_upd[c];
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_load = 1'b0;
        cap      = 1'b0;
        err_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (q_first) begin
                        acc_load = 1'b1;
                        cnt_n    = ONE;
                        if (LAST == ONE) begin
                            cap     = 1'b1;
                            state_n = S_HOLD;
                        end else begin
                            state_n = S_ACCUM;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_load = 1'b1;
                    if (q_first) begin
                        err_n = 1'b1;
                        cnt_n = ONE;
                        if (LAST == ONE) begin
                            cap     = 1'b1;
                            state_n = S_HOLD;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == LAST) begin
                            cap     = 1'b1;
                            state_n = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    // Handshake cycle doubles as an IDLE cycle so vectors stream without bubbles.
                    if (accept) begin
                        if (q_first) begin
                            acc_load = 1'b1;
                            cnt_n    = ONE;
                            if (LAST == ONE) begin
                                cap     = 1'b1;
                                state_n = S_HOLD;
                            end else begin
                                state_n = S_ACCUM;
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            err_restart <= 1'b0;
            out_data    <= '0;
            for (int c = 0; c < NCOL; c++) begin
                acc[c] <= '0;
            end
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            err_restart <= err_n;
            if (acc_load) begin
                for (int c = 0; c < NCOL; c++) begin
                    acc[c] <= acc_upd[c];
                end
            end
            if (cap) begin
                out_data <= acc_flat;
            end
        end
    end

endmodule

// File: tb/tb_cim_psum_accum.sv
// tb/tb_cim_psum_accum.sv - directed table-driven bench for cim_psum_accum
module tb_cim_psum_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_valid;
    logic        q_ready;
    logic        q_first;
    logic [15:0] q_data;
    logic [3:0]  q_col_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        err_restart;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cim_psum_accum #(
        .NCOL(4), .Q_W(4), .IN_BITS(4), .ACC_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .q_valid(q_valid), .q_ready(q_ready), .q_first(q_first),
        .q_data(q_data), .q_col_en(q_col_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_restart(err_restart)
    );

    typedef struct packed {
        logic [3:0][15:0] d;
        logic [3:0][3:0]  en;
        logic [31:0]      exp;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3,
                           input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3,
                           input logic [31:0] exp);
        tbl[i].d   = {p3, p2, p1, p0};
        tbl[i].en  = {e3, e2, e1, e0};
        tbl[i].exp = exp;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            q_valid = 1'b0;
            q_first = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic first, input logic [15:0] d, input logic [3:0] en);
        q_valid  = 1'b1;
        q_first  = first;
        q_data   = d;
        q_col_en = en;
        #1;
        chk("q_ready_on_send", q_ready, 1);
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        q_first = 1'b0;
    endtask

    task automatic send_vec(input int i, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            send(k == 0, tbl[i].d[k], tbl[i].en[k]);
            chk("err_restart_quiet", err_restart, 0);
            if (k < 3) chk("out_valid_mid_vector", out_valid, 0);
        end
        chk("out_valid_after_last", out_valid, 1);
        chk("out_data_vec", out_data, tbl[i].exp);
    endtask

    initial begin
        // full-scale, col0 masked pattern, col0 extra mask on third plane, mixed values
        set_vec(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                4'hF, 4'hF, 4'hF, 4'hF, 32'hE1E1_E1E1);
        set_vec(1, 16'hFFF3, 16'hFFF0, 16'hFFF1, 16'hFFF2,
                4'b0101, 4'b0101, 4'b0101, 4'b0101, 32'h00E1_001C);
        set_vec(2, 16'hFFF3, 16'hFFF0, 16'hFFF1, 16'hFFF2,
                4'b0101, 4'b0101, 4'b0100, 4'b0101, 32'h00E1_001A);
        set_vec(3, 16'h0501, 16'hFA00, 16'h0300, 16'hFC10,
                4'hF, 4'hF, 4'hF, 4'hF, 32'h4B62_0108);

        rst = 1'b1; q_valid = 1'b0; q_first = 1'b0; q_data = '0; q_col_en = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_q_ready", q_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_err", err_restart, 0);
        rst = 1'b0;
        #1;
        chk("q_ready_after_release", q_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) send_vec(i, 0);

        // backpressure: result held, input stalled, then simultaneous handshake + first plane
        idle(1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(k == 0, tbl[3].d[k], tbl[3].en[k]);
        for (int n = 0; n < 5; n++) begin
            q_valid = 1'b1; q_first = 1'b1; q_data = tbl[0].d[0]; q_col_en = tbl[0].en[0];
            #1;
            chk("bp_q_ready_low", q_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data_stable", out_data, 32'h4B62_0108);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(1'b1, tbl[0].d[0], tbl[0].en[0]);
        chk("bp_handshake_done", out_valid, 0);
        for (int k = 1; k < 4; k++) begin
            send(1'b0, tbl[0].d[k], tbl[0].en[k]);
            if (k < 3) chk("bp_no_early_result", out_valid, 0);
        end
        chk("bp_next_result_valid", out_valid, 1);
        chk("bp_next_result_data", out_data, 32'hE1E1_E1E1);

        // framing error: restart after two planes
        send(1'b1, tbl[3].d[0], tbl[3].en[0]);
        send(1'b0, tbl[3].d[1], tbl[3].en[1]);
        chk("no_err_before_restart", err_restart, 0);
        send(1'b1, tbl[0].d[0], tbl[0].en[0]);
        chk("restart_err_pulse", err_restart, 1);
        send(1'b0, tbl[0].d[1], tbl[0].en[1]);
        chk("restart_err_one_cycle", err_restart, 0);
        send(1'b0, tbl[0].d[2], tbl[0].en[2]);
        send(1'b0, tbl[0].d[3], tbl[0].en[3]);
        chk("restart_result_valid", out_valid, 1);
        chk("restart_result_data", out_data, 32'hE1E1_E1E1);

        // stray non-first plane in IDLE
        idle(1);
        chk("idle_after_handshake", out_valid, 0);
        send(1'b0, 16'h1234, 4'hF);
        chk("stray_err_pulse", err_restart, 1);
        chk("stray_no_result", out_valid, 0);
        idle(1);
        chk("stray_err_one_cycle", err_restart, 0);
        send_vec(1, 0);

        // reset mid-vector
        send(1'b1, tbl[3].d[0], tbl[3].en[0]);
        send(1'b0, tbl[3].d[1], tbl[3].en[1]);
        rst = 1'b1;
        #1;
        chk("rst_q_ready_comb", q_ready, 0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_err", err_restart, 0);
        rst = 1'b0;
        #1;
        chk("midrst_q_ready_release", q_ready, 1);
        for (int n = 0; n < 6; n++) begin
            idle(1);
            chk("midrst_no_result", out_valid, 0);
            chk("midrst_no_err", err_restart, 0);
        end

        // same vector with random input gaps
        send_vec(3, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
